// File: rtl/add_sub_pkg.sv
// Shared definitions for the digit-serial adder/subtractor: mode codes,
// FSM state encoding and the parameter legality check.
package add_sub_pkg;

  localparam logic ADD_OP = 1'b0;
  localparam logic SUB_OP = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // True when WIDTH splits into a whole number of DIGIT-bit slices.
  function automatic bit width_ok(input int width, input int digit);
    return (digit >= 1) && (digit <= width) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/add_sub_digit.sv
// DIGIT-bit ripple slice; also exposes the carry into its MSB so the caller
// can derive signed overflow on the final digit.
module add_sub_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);

  logic [DIGIT:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    full_adder u_fa (
      .x    (x[i]),
      .y    (y[i]),
      .cin  (c[i]),
      .sum  (sum[i]),
      .cout (c[i+1])
    );
  end

  assign cout     = c[DIGIT];
  assign c_msb_in = c[DIGIT-1];

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell used to build the ripple digit slice.
module full_adder (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = x ^ y ^ cin;
  assign cout = (x & y) | (cin & (x ^ y));

endmodule

// File: rtl/serial_add_sub.sv
// Digit-serial two's-complement adder/subtractor with valid/ready handshakes.
// Define SERIAL_ADD_SUB_SATURATE_EN to clamp overflowing results to signed max/min.
module serial_add_sub
  import add_sub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             m,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             v,
  output logic             z,
  output logic             n
);

  localparam int            N        = WIDTH / DIGIT;
  localparam int            CW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST     = CW'(N - 1);
  localparam bit            WIDTH_OK = width_ok(WIDTH, DIGIT);

`ifdef SERIAL_ADD_SUB_SATURATE_EN
  localparam logic [WIDTH-1:0] SMIN = WIDTH'(1) << (WIDTH - 1);
  localparam logic [WIDTH-1:0] SMAX = ~SMIN;
`endif

  always_comb assert (WIDTH_OK);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] res_merge;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             c_out_q, c_out_d;
  logic             v_q, v_d;
  logic             z_q, z_d;
  logic             n_q, n_d;

  logic [DIGIT-1:0] dig_x, dig_y, dig_sum;
  logic             dig_cout, dig_c_msb;

  // b_q already holds B or ~B, so the slice only ever adds.
  assign dig_x = a_q[int'(cnt_q) * DIGIT +: DIGIT];
  assign dig_y = b_q[int'(cnt_q) * DIGIT +: DIGIT];

  add_sub_digit #(
    .DIGIT (DIGIT)
  ) u_digit (
    .x        (dig_x),
    .y        (dig_y),
    .cin      (carry_q),
    .sum      (dig_sum),
    .cout     (dig_cout),
    .c_msb_in (dig_c_msb)
  );

  // NOTE: every variable gets its hold value before the case, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    c_out_d   = c_out_q;
    v_d       = v_q;
    z_d       = z_q;
    n_d       = n_q;
    res_merge = result_q;
    res_merge[int'(cnt_q) * DIGIT +: DIGIT] = dig_sum;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = (m == ADD_OP) ? b : ~b;
          carry_d = (m == SUB_OP);
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        result_d = res_merge;
        carry_d  = dig_cout;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          c_out_d = dig_cout;
          v_d     = dig_cout ^ dig_c_msb;
`ifdef SERIAL_ADD_SUB_SATURATE_EN
          if (v_d) result_d = a_q[WIDTH-1] ? SMIN : SMAX;
`endif
          z_d     = (result_d == '0);
          n_d     = result_d[WIDTH-1];
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments make every flop sample pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      c_out_q  <= 1'b0;
      v_q      <= 1'b0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      c_out_q  <= c_out_d;
      v_q      <= v_d;
      z_q      <= z_d;
      n_q      <= n_d;
    end
  end

  // NOTE: operand registers are always loaded at accept before being read, so they carry no reset.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign c_out     = c_out_q;
  assign v         = v_q;
  assign z         = z_q;
  assign n         = n_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Scoreboard bench for serial_add_sub: directed cases plus randomized operations
// checked against an integer-arithmetic reference model.
module tb_serial_add_sub;

  localparam int WIDTH = 16;
  localparam int DIGIT = 4;
  localparam int N     = WIDTH / DIGIT;

  typedef struct {
    logic [WIDTH-1:0] result;
    logic             c;
    logic             v;
    logic             z;
    logic             n;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a, b;
  logic             m;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             c_out, v, z, n;

  int   checks = 0;
  int   errors = 0;
  bit   rand_ready = 1'b0;
  exp_t sb[$];

  serial_add_sub #(
    .WIDTH (WIDTH),
    .DIGIT (DIGIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .m         (m),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .c_out     (c_out),
    .v         (v),
    .z         (z),
    .n         (n)
  );

  always #5 clk = ~clk;

  // Reference: exact signed/unsigned integer arithmetic, then wrap or clamp.
  function automatic exp_t model(input logic [WIDTH-1:0] fa, input logic [WIDTH-1:0] fb,
                                 input logic fm);
    exp_t   r;
    longint sa    = longint'($signed(fa));
    longint sb_v  = longint'($signed(fb));
    longint ua    = longint'(fa);
    longint ub    = longint'(fb);
    longint lim   = longint'(1) << (WIDTH - 1);
    longint exact = fm ? (sa - sb_v) : (sa + sb_v);
    r.c      = fm ? (ua >= ub) : ((ua + ub) >= (longint'(1) << WIDTH));
    r.v      = (exact >= lim) || (exact < -lim);
    r.result = exact[WIDTH-1:0];
`ifdef SERIAL_ADD_SUB_SATURATE_EN
    if (r.v) r.result = (exact > 0) ? WIDTH'(lim - 1) : WIDTH'(lim);
`endif
    r.z = (r.result == '0);
    r.n = r.result[WIDTH-1];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Monitor: pops one expectation per output handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got result 0x%0h with no operation pending", result);
      end else begin
        e = sb.pop_front();
        check("result", result, e.result);
        check("c_out", c_out, e.c);
        check("v", v, e.v);
        check("z", z, e.z);
        check("n", n, e.n);
      end
    end
  end

  task automatic wait_in_ready();
    int budget = 200;
    while (!in_ready && budget > 0) begin
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
      budget--;
    end
    if (!in_ready) fail_timeout("in_ready_wait");
  endtask

  task automatic issue(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib, input logic im);
    wait_in_ready();
    a        = ia;
    b        = ib;
    m        = im;
    in_valid = 1'b1;
    sb.push_back(model(ia, ib, im));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int budget = 1000;
    while (sb.size() != 0 && budget > 0) begin
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
      budget--;
    end
    if (sb.size() != 0) begin
      fail_timeout("drain");
      sb.delete();
    end
    out_ready = 1'b1;
  endtask

  function automatic logic [WIDTH-1:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return 16'h7FFF;
      1:       return 16'h8000;
      2:       return 16'hFFFF;
      3:       return 16'h0000;
      default: return WIDTH'($urandom);
    endcase
  endfunction

  initial begin
    exp_t e;
    int   cyc;

    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    m         = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_flags", {c_out, v, z, n}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Add with latency measurement: handshake cycle is cycle 0.
    issue(16'h1234, 16'h0F0F, 1'b0);
    cyc = 1;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", cyc, N + 1);
    drain();

    issue(16'h0005, 16'h0007, 1'b1);
    issue(16'h0003, 16'h0003, 1'b1);
    issue(16'h7FFF, 16'h0001, 1'b0);
    issue(16'h8000, 16'h0001, 1'b1);
    drain();

    // Backpressure: result held for 10 cycles with in_ready low.
    out_ready = 1'b0;
    issue(16'h9ABC, 16'h1357, 1'b1);
    e   = model(16'h9ABC, 16'h1357, 1'b1);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!out_valid) fail_timeout("bp_out_valid");
    for (int i = 0; i < 10; i++) begin
      check("bp_result", result, e.result);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    check("bp_flags", {c_out, v, z, n}, {e.c, e.v, e.z, e.n});
    out_ready = 1'b1;
    check("bp_in_ready_same", in_ready, 0);
    @(posedge clk); #1;
    check("bp_in_ready_next", in_ready, 1);
    check("bp_out_valid_next", out_valid, 0);
    drain();

    // Reset two cycles into RUN aborts the operation.
    issue(16'h4444, 16'h1111, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_result", result, 0);
    check("abort_flags", {c_out, v, z, n}, 0);
    rst = 1'b0;
    issue(16'h0001, 16'h0001, 1'b0);
    drain();

    // Inputs wiggle through RUN and DONE; only the accepted operands count.
    issue(16'h2468, 16'h1357, 1'b1);
    for (int i = 0; i < N + 1; i++) begin
      a        = WIDTH'($urandom);
      b        = WIDTH'($urandom);
      m        = 1'($urandom);
      in_valid = 1'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();

    // Randomized operations with random output backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      issue(rand_operand(), rand_operand(), 1'($urandom));
    end
    drain();
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
